phase_sequencer: RTL and testbench

Parametrised successor to the fixed 4-phase, 64-cycle phase generator used by the ASK/FSK transmitter. A dwell counter runs up to a programmable terminal count. On each wrap, a PH_W-bit phase register steps by a programmable amount, up or down, modulo 2^PH_W. The block drives symbol phase selection for the modulator datapath. Its default configuration reproduces the legacy behaviour: 64-cycle dwell, phases 0→1→2→3→0.

---
 rtl/phase_sequencer.sv | 86 ++++++++
 tb/tb_phase_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Dwell counter with a shadowed terminal count. On each wrap it steps a
//            modular phase register up or down and emits a registered tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer #(
    parameter int CNT_W = 6,
    parameter int PH_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic [CNT_W-1:0]      period,
    input  logic [PH_W-1:0]       step,
    input  logic                  dir,
    output logic [CNT_W-1:0]      cnt,
    output logic [PH_W-1:0]       phase,
    output logic [(1<<PH_W)-1:0]  phase_oh,
    output logic                  tick
);

    localparam int N_PH = 1 << PH_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             tick_q, tick_d;
    logic             w_wrap;

    // Terminal detect looks only at the shadow, so live period edits mid-dwell are inert.
    assign w_wrap = en & ~sync_clr & (cnt_q == period_q);

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        period_d = period_q;
        tick_d   = 1'b0;
        if (sync_clr) begin
            cnt_d    = '0;
            phase_d  = '0;
            period_d = period;
        end else if (!en) begin
            cnt_d    = cnt_q;
        end else if (w_wrap) begin
            cnt_d    = '0;
            phase_d  = dir ? (phase_q + step) : (phase_q - step);
            period_d = period;
            tick_d   = 1'b1;
        end else begin
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // All-ones shadow at reset gives the full-length first dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            phase_q  <= '0;
            period_q <= '1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        phase_oh = '0;
        for (int i = 0; i < N_PH; i++) begin
            phase_oh[i] = (phase_q == PH_W'(i));
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;
    assign tick  = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module   : tb_phase_sequencer
// Purpose  : Directed, self-checking bench for phase_sequencer (default widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync_clr;
    logic [5:0] period;
    logic [1:0] step;
    logic       dir;
    logic [5:0] cnt;
    logic [1:0] phase;
    logic [3:0] phase_oh;
    logic       tick;

    int tests;
    int fails;

    phase_sequencer #(.CNT_W(6), .PH_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .period   (period),
        .step     (step),
        .dir      (dir),
        .cnt      (cnt),
        .phase    (phase),
        .phase_oh (phase_oh),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input int p, input int t);
        chk({tag, ".cnt"},   32'(cnt),      32'(c));
        chk({tag, ".phase"}, 32'(phase),    32'(p));
        chk({tag, ".oh"},    32'(phase_oh), 32'(1 << p));
        chk({tag, ".tick"},  32'(tick),     32'(t));
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; en = 1'b0; sync_clr = 1'b0;
        period = 6'd63; step = 2'd1; dir = 1'b1;

        // Reset state
        #12;
        chk_state("reset", 0, 0, 0);
        adv(1);
        rst = 1'b1;
        en  = 1'b1;

        // Defaults: 64-cycle dwell, phases 0..3
        adv(63);  chk_state("def63", 63, 0, 0);
        adv(1);   chk_state("def64", 0, 1, 1);
        adv(1);   chk_state("def65", 1, 1, 0);
        adv(63);  chk_state("def128", 0, 2, 1);
        adv(64);  chk_state("def192", 0, 3, 1);
        adv(64);  chk_state("def256", 0, 0, 1);

        // Shadow load: period change at cycle 10 waits for the first wrap
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        adv(10);  period = 6'd9;
        adv(53);  chk_state("sh63", 63, 0, 0);
        adv(1);   chk_state("sh64", 0, 1, 1);
        adv(9);   chk_state("sh73", 9, 1, 0);
        adv(1);   chk_state("sh74", 0, 2, 1);
        adv(10);  chk_state("sh84", 0, 3, 1);

        // Down-stepping by 3 mod 4
        period = 6'd3; step = 2'd3; dir = 1'b0; sync_clr = 1'b1;
        adv(1);   sync_clr = 1'b0;
        chk_state("dn_clr", 0, 0, 0);
        adv(3);   chk_state("dn3", 3, 0, 0);
        adv(1);   chk_state("dn4", 0, 1, 1);
        adv(4);   chk_state("dn8", 0, 2, 1);
        adv(4);   chk_state("dn12", 0, 3, 1);
        adv(4);   chk_state("dn16", 0, 0, 1);

        // Enable gating at terminal count
        adv(3);   chk_state("en_pre", 3, 0, 0);
        en = 1'b0;
        adv(5);   chk_state("en_hold", 3, 0, 0);
        en = 1'b1;
        adv(1);   chk_state("en_wrap", 0, 1, 1);

        // period 0: wrap every cycle, tick continuously high
        period = 6'd0; step = 2'd1; dir = 1'b1; sync_clr = 1'b1;
        adv(1);   sync_clr = 1'b0;
        chk_state("p0_clr", 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            adv(1);
            chk_state($sformatf("p0_%0d", k), 0, k % 4, 1);
        end
        sync_clr = 1'b1;
        adv(1);   sync_clr = 1'b0;
        chk_state("p0_clrwin", 0, 0, 0);

        // Async reset mid-dwell at cnt=37, phase=2
        period = 6'd63; sync_clr = 1'b1;
        adv(1);   sync_clr = 1'b0;
        adv(128); chk_state("ar128", 0, 2, 1);
        adv(37);  chk_state("ar37", 37, 2, 0);
        period = 6'd5;
        #2 rst = 1'b0;
        #1 chk_state("ar_async", 0, 0, 0);
        rst = 1'b1;
        adv(63);  chk_state("ar_r63", 63, 0, 0);
        adv(1);   chk_state("ar_r64", 0, 1, 1);
        adv(6);   chk_state("ar_r70", 0, 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
